pc_fetch_sequencer: RTL

- Program-counter register and fetch sequencer that consumes the output of the next-PC mux chain and presents the current PC to instruction memory.
- Selects the next PC from PC+4, branch target or jump target, and advances only after instruction memory acknowledges the fetch.
- Sits in the fetch stage, directly downstream of the 2:1 mux selection logic and upstream of the instruction-decode stage.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_next_sel.sv | 28 ++
 rtl/pc_fetch_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential, branch and jump targets combined by a 2:1 mux chain.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_offset_i,
  input  logic            jmp_i,
  input  logic [PC_W-1:0] jmp_offset_i,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic [PC_W-1:0] next_pc_o
);

  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] seq_or_br;

  // Modulo-2^PC_W adds; negative offsets wrap naturally.
  assign pc_plus4_o = pc_i + PC_W'(PC_STEP);
  assign br_tgt     = pc_i + br_offset_i;
  assign jmp_tgt    = pc_i + jmp_offset_i;

  assign seq_or_br  = br_taken_i ? br_tgt  : pc_plus4_o;
  assign next_pc_o  = jmp_i      ? jmp_tgt : seq_or_br;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register and fetch FSM (IDLE/REQ/ISSUE/HALT).
// Optional alignment trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_offset,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_offset,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            imem_req,
  output logic            pc_valid,
  output logic            halted,
  output logic            misaligned
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic            imem_req_q, pc_valid_q, halted_q;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] load_pc;
  logic            trap_c;

  pc_next_sel #(
    .PC_W (PC_W)
  ) u_next_sel (
    .pc_i         (pc_q),
    .br_taken_i   (br_taken),
    .br_offset_i  (br_offset),
    .jmp_i        (jmp),
    .jmp_offset_i (jmp_offset),
    .pc_plus4_o   (pc_plus4),
    .next_pc_o    (next_pc)
  );

`ifdef PC_MISALIGN_TRAP_EN
  assign load_pc = next_pc;
  assign trap_c  = |next_pc[1:0];
`else
  // Without the trap, targets are silently word-aligned.
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
  assign load_pc = next_pc & ALIGN_MASK;
  assign trap_c  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      mis_q      <= 1'b0;
      imem_req_q <= 1'b0;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      imem_req_q <= (state_d == ST_REQ);
      pc_valid_q <= (state_d == ST_ISSUE);
      halted_q   <= (state_d == ST_HALT);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: begin
        state_d = halt ? ST_HALT : ST_REQ;
      end
      ST_REQ: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (imem_ready) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Redirects and halt are only honoured once decode accepts.
        if (!stall) begin
          pc_d    = load_pc;
          state_d = halt ? ST_HALT : ST_REQ;
          if (trap_c) begin
            mis_d   = 1'b1;
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pc         = pc_q;
  assign imem_req   = imem_req_q;
  assign pc_valid   = pc_valid_q;
  assign halted     = halted_q;
  assign misaligned = mis_q;

endmodule
